pzvbus_fifo_scheduler: RTL and testbench

//  Credit-based round-robin scheduler draining N pzvbus FIFOs (valid+payload, no ready) onto one shared pzvbus link.

---
 rtl/pzvbus_fifo_scheduler_pkg.sv | 24 ++
 rtl/pzvbus_rr_arbiter.sv | 35 +++
 rtl/pzvbus_fifo_scheduler.sv | 114 +++++++++++
 tb/tb_pzvbus_fifo_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pzvbus_fifo_scheduler_pkg.sv
// Shared helpers for the pzvbus FIFO scheduler: port-width functions and one-hot decode.
package pzvbus_fifo_scheduler_pkg;

    localparam int MAX_SOURCES = 16;

    function automatic int cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the set bit; zero when the vector is empty.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_SOURCES-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int b = 0; b < MAX_SOURCES; b++) begin
            if (oh[b]) idx = idx | 4'(b);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pzvbus_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping.
module pzvbus_rr_arbiter
    import pzvbus_fifo_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [id_w(N)-1:0]   ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [id_w(N)-1:0]   idx_o,
    output logic                 any_o
);

    localparam int IDW = id_w(N);

    logic found;
    int   cand;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = 0;
        for (int o = 0; o < N; o++) begin
            cand = (int'(ptr_i) + o) % N;
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign idx_o = IDW'(onehot_to_idx(MAX_SOURCES'(grant_o)));
    assign any_o = |req_i;

endmodule

// File: rtl/pzvbus_fifo_scheduler.sv
// Credit-based round-robin drain of N pzvbus FIFOs onto one link.
// Optional urgent-priority input enabled by PZVBUS_FIFO_SCHEDULER_URGENT_EN.
module pzvbus_fifo_scheduler
    import pzvbus_fifo_scheduler_pkg::*;
#(
    parameter int N       = 4,
    parameter int WIDTH   = 32,
    parameter int CREDITS = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic [N-1:0]                i_empty,
    input  logic [N*WIDTH-1:0]          i_payload,
`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
    input  logic [N-1:0]                i_urgent,
`endif
    output logic [N-1:0]                o_pop,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_payload,
    output logic [id_w(N)-1:0]          o_grant_id,
    input  logic                        i_credit_return,
    output logic [cnt_w(CREDITS)-1:0]   o_credit_count,
    output logic                        o_credit_error
);

    localparam int IDW = id_w(N);
    localparam int CW  = cnt_w(CREDITS);

    logic [N-1:0]     nonempty;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDW-1:0]   win_idx;
    logic             req_any;
    logic             issue;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic             err_q, err_d;
    logic             valid_q;
    logic [WIDTH-1:0] payload_q;
    logic [IDW-1:0]   gid_q;

    assign nonempty = ~i_empty;

`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
    // Urgent sources shadow everyone else; RR still runs among them.
    assign req = (|(nonempty & i_urgent)) ? (nonempty & i_urgent) : nonempty;
`else
    assign req = nonempty;
`endif

    pzvbus_rr_arbiter #(.N(N)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (req_any)
    );

    // Pops are forced low while reset is asserted so no word leaves a FIFO unseen.
    assign issue = i_rst_n && (credit_q != '0) && req_any && !i_clear;
    assign o_pop = issue ? grant : '0;

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        err_d    = err_q;
        if (issue) begin
            ptr_d = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
        end
        if (issue && !i_credit_return) begin
            credit_d = credit_q - 1'b1;
        end else if (!issue && i_credit_return) begin
            if (credit_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            credit_q  <= CW'(CREDITS);
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            payload_q <= '0;
            gid_q     <= '0;
        end else if (i_clear) begin
            ptr_q     <= '0;
            credit_q  <= CW'(CREDITS);
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            credit_q  <= credit_d;
            err_q     <= err_d;
            valid_q   <= issue;
            if (issue) begin
                payload_q <= i_payload[win_idx*WIDTH +: WIDTH];
                gid_q     <= win_idx;
            end
        end
    end

    assign o_valid        = valid_q;
    assign o_payload      = payload_q;
    assign o_grant_id     = gid_q;
    assign o_credit_count = credit_q;
    assign o_credit_error = err_q;

endmodule

// File: tb/tb_pzvbus_fifo_scheduler.sv
// Directed self-checking bench for pzvbus_fifo_scheduler (N=4, WIDTH=32, CREDITS=8).
// Urgent-priority vectors run only when PZVBUS_FIFO_SCHEDULER_URGENT_EN is defined.
module tb_pzvbus_fifo_scheduler;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [3:0]   empty;
    logic [127:0] payload;
    logic [3:0]   pop;
    logic         valid;
    logic [31:0]  link_payload;
    logic [1:0]   grant_id;
    logic         credit_return;
    logic [3:0]   credit_count;
    logic         credit_error;
`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
    logic [3:0]   urgent;
`endif

    int n_chk;
    int n_fail;

    pzvbus_fifo_scheduler #(.N(4), .WIDTH(32), .CREDITS(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_clear         (clear),
        .i_empty         (empty),
        .i_payload       (payload),
`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
        .i_urgent        (urgent),
`endif
        .o_pop           (pop),
        .o_valid         (valid),
        .o_payload       (link_payload),
        .o_grant_id      (grant_id),
        .i_credit_return (credit_return),
        .o_credit_count  (credit_count),
        .o_credit_error  (credit_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        empty = 4'b1111;
        credit_return = 1'b0;
        payload = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
        urgent = 4'b0000;
`endif
        cyc();
        cyc();
        check("rst_valid",  64'(valid), 64'h0);
        check("rst_count",  64'(credit_count), 64'd8);
        check("rst_err",    64'(credit_error), 64'h0);
        check("rst_gid",    64'(grant_id), 64'h0);
        check("rst_pay",    64'(link_payload), 64'h0);
        check("rst_pop",    64'(pop), 64'h0);
        rst_n = 1'b1;
        cyc();

        // 1: all FIFOs busy, credits run out after eight words.
        empty = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("t1_pop%0d", i), 64'(pop), 64'(4'b0001 << (i % 4)));
            cyc();
            check($sformatf("t1_valid%0d", i), 64'(valid), 64'h1);
            check($sformatf("t1_gid%0d", i), 64'(grant_id), 64'(i % 4));
            check($sformatf("t1_pay%0d", i), 64'(link_payload), 64'(32'hA0 + (i % 4)));
            check($sformatf("t1_cnt%0d", i), 64'(credit_count), 64'(7 - i));
        end
        #1 check("t1_pop_starved", 64'(pop), 64'h0);
        cyc();
        check("t1_valid_off", 64'(valid), 64'h0);
        check("t1_pay_hold",  64'(link_payload), 64'hA3);
        check("t1_gid_hold",  64'(grant_id), 64'h3);

        // 2: single requester FIFO2 with steady credit return.
        clear = 1'b1;
        #1 check("t2_clear_pop", 64'(pop), 64'h0);
        cyc();
        clear = 1'b0;
        empty = 4'b1011;
        #1 check("t2_first_pop", 64'(pop), 64'b0100);
        cyc();
        check("t2_cnt_first", 64'(credit_count), 64'd7);
        credit_return = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check($sformatf("t2_pop%0d", i), 64'(pop), 64'b0100);
            cyc();
            check($sformatf("t2_cnt%0d", i), 64'(credit_count), 64'd7);
            check($sformatf("t2_gid%0d", i), 64'(grant_id), 64'h2);
        end
        credit_return = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        check("t2_drained", 64'(credit_count), 64'd0);

        // 3: a returned credit becomes usable only on the following cycle.
        empty = 4'b1101;
        credit_return = 1'b1;
        #1 check("t3_pop_at_t", 64'(pop), 64'h0);
        cyc();
        credit_return = 1'b0;
        check("t3_cnt_t1", 64'(credit_count), 64'd1);
        check("t3_valid_t1", 64'(valid), 64'h0);
        #1 check("t3_pop_t1", 64'(pop), 64'b0010);
        cyc();
        check("t3_valid_t2", 64'(valid), 64'h1);
        check("t3_gid_t2", 64'(grant_id), 64'h1);
        check("t3_cnt_t2", 64'(credit_count), 64'd0);

        // 4: surplus return at full count sets the sticky error.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        empty = 4'b1111;
        credit_return = 1'b1;
        cyc();
        credit_return = 1'b0;
        check("t4_cnt_sat", 64'(credit_count), 64'd8);
        check("t4_err_set", 64'(credit_error), 64'h1);
        cyc();
        cyc();
        check("t4_err_sticky", 64'(credit_error), 64'h1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check("t4_err_clr", 64'(credit_error), 64'h0);

        // 5: pops 0,1,2,3,0,1 with one overlapped return -> count 3, pointer 2.
        empty = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            credit_return = (i == 2);
            cyc();
        end
        credit_return = 1'b0;
        check("t5_cnt_pre", 64'(credit_count), 64'd3);
        clear = 1'b1;
        #1 check("t5_clear_pop", 64'(pop), 64'h0);
        cyc();
        clear = 1'b0;
        check("t5_cnt_clr", 64'(credit_count), 64'd8);
        check("t5_valid_clr", 64'(valid), 64'h0);
        // Non-empty {1,3}: a stale pointer of 2 would pick 3.
        empty = 4'b0101;
        #1 check("t5_pop_ptr0", 64'(pop), 64'b0010);
        cyc();
        check("t5_gid", 64'(grant_id), 64'h1);

`ifdef PZVBUS_FIFO_SCHEDULER_URGENT_EN
        // 6: urgent FIFO3 dominates until empty, then RR resumes at 0.
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        empty = 4'b0100;
        urgent = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t6_urg%0d", i), 64'(pop), 64'b1000);
            cyc();
        end
        empty = 4'b1100;
        #1 check("t6_rr0", 64'(pop), 64'b0001);
        cyc();
        #1 check("t6_rr1", 64'(pop), 64'b0010);
        cyc();
        urgent = 4'b0000;
`endif

        // Async reset mid-stream clears outputs without waiting for a clock edge.
        empty = 4'b0000;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(valid), 64'h0);
        check("ar_pop",   64'(pop), 64'h0);
        check("ar_cnt",   64'(credit_count), 64'd8);
        check("ar_pay",   64'(link_payload), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
